// File: rtl/count_window_monitor.sv
// count_window_monitor: classifies counter samples (step/wrap/window with hysteresis); COUNT_MON_DEBOUNCE_EN adds transition debounce
module count_window_monitor #(
  parameter int HYST = 2,
  parameter int WCW = 4,
  parameter int DEB_LEN = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           sample_en,
  input  logic [7:0]     count,
  input  logic [7:0]     hi_thresh,
  input  logic [7:0]     lo_thresh,
  input  logic           clear,
  output logic [1:0]     state,
  output logic           above,
  output logic           below,
  output logic           wrap_up,
  output logic           wrap_dn,
  output logic           jump,
  output logic           alarm,
  output logic [WCW-1:0] wrap_cnt,
  output logic           cfg_err
);
  typedef enum logic [1:0] {INIT = 2'b00, IN_RANGE = 2'b01, ABOVE = 2'b10, BELOW = 2'b11} state_t;
  state_t cur, nxt, tgt;
  logic [7:0] prev, delta;
  logic prev_valid, cfg_bad, is_wu, is_wd, is_jump, wrap_ev, go, set_alarm;
  logic [8:0] exit_hi, exit_lo;
  always_comb begin
    cfg_bad = lo_thresh > hi_thresh;
    exit_hi = ({1'b0, hi_thresh} >= 9'(HYST)) ? {1'b0, hi_thresh} - 9'(HYST) : 9'd0;
    exit_lo = ({1'b0, lo_thresh} + 9'(HYST) > 9'd255) ? 9'd255 : {1'b0, lo_thresh} + 9'(HYST);
    delta = count - prev;
    is_wu = prev_valid && prev == 8'hff && count == 8'h00;
    is_wd = prev_valid && prev == 8'h00 && count == 8'hff;
    is_jump = prev_valid && !is_wu && !is_wd && delta != 8'd0 && delta != 8'd1 && delta != 8'hff;
    wrap_ev = sample_en && (is_wu || is_wd);
    if (cur == INIT || cur == IN_RANGE)
      tgt = count > hi_thresh ? ABOVE : count < lo_thresh ? BELOW : IN_RANGE;
    else if (cur == ABOVE)
      tgt = count < lo_thresh ? BELOW : {1'b0, count} <= exit_hi ? IN_RANGE : ABOVE;
    else
      tgt = count > hi_thresh ? ABOVE : {1'b0, count} >= exit_lo ? IN_RANGE : BELOW;
  end
`ifdef COUNT_MON_DEBOUNCE_EN
  state_t run_tgt;
  logic [7:0] run_cnt, hits;
  always_comb begin
    hits = (tgt == run_tgt ? run_cnt : 8'd0) + 8'd1;
    go = hits >= 8'(DEB_LEN);
  end
  // run counts consecutive samples pointing at the same non-current target
  always_ff @(posedge clk)
    if (reset) begin
      run_tgt <= INIT;
      run_cnt <= 8'd0;
    end else if (sample_en && !cfg_bad && cur != INIT) begin
      run_tgt <= tgt;
      run_cnt <= (tgt == cur || go) ? 8'd0 : hits;
    end
`else
  assign go = 1'b1;
`endif
  always_comb begin
    nxt = (sample_en && !cfg_bad && (cur == INIT || go)) ? tgt : cur;
    set_alarm = nxt != cur && (nxt == ABOVE || nxt == BELOW);
  end
  always_ff @(posedge clk)
    if (reset) cur <= INIT;
    else cur <= nxt;
  always_ff @(posedge clk)
    if (reset) begin
      prev <= 8'd0;
      prev_valid <= 1'b0;
      wrap_up <= 1'b0;
      wrap_dn <= 1'b0;
      jump <= 1'b0;
      alarm <= 1'b0;
      wrap_cnt <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_bad;
      wrap_up <= sample_en && is_wu;
      wrap_dn <= sample_en && is_wd;
      jump <= sample_en && is_jump;
      if (sample_en) begin
        prev <= count;
        prev_valid <= 1'b1;
      end
      alarm <= set_alarm || (alarm && !clear);
      wrap_cnt <= clear ? WCW'(wrap_ev) : (wrap_ev && !(&wrap_cnt)) ? wrap_cnt + 1'b1 : wrap_cnt;
    end
  assign state = cur;
  assign above = cur == ABOVE;
  assign below = cur == BELOW;
endmodule

// File: doc/count_window_monitor.md
Name: count_window_monitor

Overview:
Sits directly downstream of the 8-bit up/down counter and consumes its count output. Each qualified count sample is classified three ways:
- step type: up, down, hold or jump (load)
- wrap-around: 255->0 or 0->255
- window position: against programmable high/low thresholds, with hysteresis

It produces registered status flags, single-cycle event pulses, a sticky alarm and a saturating wrap counter for the control/status logic.

Parameters:
HYST, 2, hysteresis in counts applied when leaving ABOVE/BELOW (0..15)
WCW, 4, width of wrap event counter
DEB_LEN, 3, consecutive qualifying samples required per transition (used only with COUNT_MON_DEBOUNCE_EN)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous active-high reset
sample_en  input  1  count is valid this cycle; sampled only when high
count  input  8  counter value being monitored
hi_thresh  input  8  upper window bound (inclusive in-range)
lo_thresh  input  8  lower window bound (inclusive in-range)
clear  input  1  clears alarm and wrap_cnt
state  output  2  00 INIT, 01 IN_RANGE, 10 ABOVE, 11 BELOW
above  output  1  state==ABOVE
below  output  1  state==BELOW
wrap_up  output  1  one-cycle pulse, 255->0 seen
wrap_dn  output  1  one-cycle pulse, 0->255 seen
jump  output  1  one-cycle pulse, non-unit non-zero delta (load)
alarm  output  1  sticky, set on entry to ABOVE or BELOW
wrap_cnt  output  WCW  saturating count of wrap events
cfg_err  output  1  lo_thresh > hi_thresh

Behaviour:
- Reset: synchronous; takes priority over all other inputs, including mid-sequence and same-cycle sample_en.
  - state=INIT; prev_valid=0.
  - All outputs 0.
- Latency: all outputs are registered and update the cycle after the sample_en cycle. Pulses last exactly one cycle.
- No sample (sample_en=0): state, prev and flags hold; pulses are 0.
- Delta classification:
  - delta = count - prev, modulo 256.
  - Only evaluated when prev_valid=1.
  - The first sample after reset only loads prev and sets prev_valid.
- Step types:
  - prev=255 and count=0: wrap_up.
  - prev=0 and count=255: wrap_dn.
  - This applies even if the step came from a load.
  - delta not in {0, 1, 255} and not a wrap: jump.
  - delta 0: no event.
- wrap_cnt:
  - Increments on wrap_up or wrap_dn.
  - Saturates at all-ones.
- cfg_err:
  - Registered each cycle from lo_thresh > hi_thresh.
  - While set, the FSM holds its state and alarm is not set.
  - prev and wrap logic keep running.
- FSM, evaluated on sample_en with cfg_err=0. Compare arithmetic is 9-bit: the exit_hi calculation clamps at 0 and the exit_lo calculation clamps at 255.
  - INIT: count>hi_thresh -> ABOVE; count<lo_thresh -> BELOW; else IN_RANGE.
  - IN_RANGE: count>hi_thresh -> ABOVE; count<lo_thresh -> BELOW; else stay.
  - ABOVE: count<lo_thresh -> BELOW; else count<=exit_hi (hi_thresh-HYST) -> IN_RANGE; else stay.
  - BELOW: count>hi_thresh -> ABOVE; else count>=exit_lo (lo_thresh+HYST) -> IN_RANGE; else stay.
- alarm:
  - Set on any transition into ABOVE or BELOW, including from INIT.
  - clear resets alarm and wrap_cnt.
  - If a set event and clear occur in the same cycle, the set wins: alarm=1, and wrap_cnt becomes 1 if a wrap occurred, else 0.
- Thresholds: may change at any time. They take effect on the next sample; no retroactive evaluation.

Optional Feature:
COUNT_MON_DEBOUNCE_EN
- Defined:
  - Each FSM transition out of IN_RANGE, ABOVE or BELOW requires DEB_LEN consecutive samples that qualify for the same target state.
  - A per-target run counter resets on any non-qualifying sample or a change of target.
  - INIT classification stays immediate.
  - Wrap/jump pulses are not debounced.
- Undefined: transitions occur on the first qualifying sample; the run counter logic is absent.

Test Plan:
- Threshold entry: reset, hi=200, lo=50, samples 10,11 -> first sample: state=BELOW, alarm=1 one cycle after; second sample: no event.
- Wrap up: samples 254,255,0 -> wrap_up pulses once after the 0 sample; wrap_cnt=1. Samples 0,255 -> wrap_dn pulses; wrap_cnt=2.
- Jump: samples 100 then 37 -> jump=1 for one cycle; wrap pulses 0.
- Hysteresis: hi=200, HYST=2:
  - Samples 201 -> ABOVE.
  - 199 -> stays ABOVE.
  - 198 -> IN_RANGE.
  - 201 -> ABOVE again; alarm stays 1.
  - clear with no event -> alarm=0.
- Saturation and clear race: WCW=4, 20 wraps -> wrap_cnt=15. clear in the same cycle as an entry to BELOW -> alarm=1, wrap_cnt=0.
- cfg_err and reset: lo=150, hi=100 -> cfg_err=1 and the sample 255 does not change state. Then reset asserted together with sample_en -> all outputs 0, state=INIT; the next sample produces no wrap/jump pulse.
